// File: rtl/dsp_simd_logic_sched.sv
// Shares one three-lane SIMD DSP logic unit (AND/OR/XOR) among four requesters.
// Same-op requests are bundled round-robin into one issue; results are held per requester until consumed.
module dsp_simd_logic_sched #(
    parameter int WIDTH = 12,
    parameter int LAT   = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [3:0]           req_valid_i,
    output logic [3:0]           req_ready_o,
    input  logic [7:0]           req_op_i,
    input  logic [4*WIDTH-1:0]   req_a_i,
    input  logic [4*WIDTH-1:0]   req_b_i,
    output logic [3:0]           rsp_valid_o,
    input  logic [3:0]           rsp_ready_i,
    output logic [4*WIDTH-1:0]   rsp_y_o,
    output logic [WIDTH-1:0]     dsp_a0_o,
    output logic [WIDTH-1:0]     dsp_a1_o,
    output logic [WIDTH-1:0]     dsp_a2_o,
    output logic [WIDTH-1:0]     dsp_b0_o,
    output logic [WIDTH-1:0]     dsp_b1_o,
    output logic [WIDTH-1:0]     dsp_b2_o,
    output logic [3:0]           dsp_alumode_o,
    output logic [8:0]           dsp_opmode_o,
    input  logic [WIDTH-1:0]     dsp_y0_i,
    input  logic [WIDTH-1:0]     dsp_y1_i,
    input  logic [WIDTH-1:0]     dsp_y2_i,
    output logic                 busy_o
);

    if (WIDTH < 1 || WIDTH > 12) begin : g_bad_width
        $error("dsp_simd_logic_sched: WIDTH must be 1..12");
    end
    if (LAT < 0 || LAT > 3) begin : g_bad_lat
        $error("dsp_simd_logic_sched: LAT must be 0..3");
    end

    localparam logic [3:0] ALU_AND = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [8:0] OPM_AND = 9'b000110011;
    localparam logic [8:0] OPM_OR  = 9'b000111011;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              rr_q;
    logic [1:0]              cnt_q;
    logic [2:0][WIDTH-1:0]   lane_a_q, lane_b_q;
    logic [2:0][1:0]         map_q;
    logic [2:0]              used_q;
    logic [3:0]              alumode_q;
    logic [8:0]              opmode_q;
    logic [3:0]              rsp_valid_q, rsp_valid_d;
    logic [4*WIDTH-1:0]      rsp_y_q, rsp_y_d;

    logic [3:0]              elig, member;
    logic                    found;
    logic [1:0]              leader, lop, idx, op_n, nmem;
    logic [2:0][1:0]         lmap_d;
    logic [2:0]              lused_d;
    logic                    go, capture;
    logic [2:0][WIDTH-1:0]   y_lane;

    assign y_lane = {dsp_y2_i, dsp_y1_i, dsp_y0_i};

    // Leader is the first eligible requester from rr; later same-op requesters join, up to three lanes.
    always_comb begin
        elig    = req_valid_i & ~rsp_valid_q;
        member  = '0;
        found   = 1'b0;
        leader  = '0;
        lop     = '0;
        nmem    = '0;
        lmap_d  = '0;
        lused_d = '0;
        idx     = '0;
        op_n    = '0;
        for (int j = 0; j < 4; j++) begin
            idx  = rr_q + 2'(j);
            op_n = req_op_i[2*idx +: 2];
            if (op_n == 2'b11) op_n = 2'b00;
            if (elig[idx] && (!found || (op_n == lop && nmem != 2'd3))) begin
                if (!found) begin
                    found  = 1'b1;
                    leader = idx;
                    lop    = op_n;
                end
                member[idx] = 1'b1;
                case (nmem)
                    2'd0:    begin lmap_d[0] = idx; lused_d[0] = 1'b1; end
                    2'd1:    begin lmap_d[1] = idx; lused_d[1] = 1'b1; end
                    default: begin lmap_d[2] = idx; lused_d[2] = 1'b1; end
                endcase
                nmem = nmem + 2'd1;
            end
        end
    end

    assign go      = (state_q == IDLE) && found;
    assign capture = (state_q == EXEC) && (cnt_q == 2'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = EXEC;
            EXEC:    if (cnt_q == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop before capture; capture never hits a held response since those requesters were not eligible.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ready_i;
        rsp_y_d     = rsp_y_q;
        if (capture) begin
            for (int k = 0; k < 3; k++) begin
                if (used_q[k]) begin
                    rsp_valid_d[map_q[k]]               = 1'b1;
                    rsp_y_d[map_q[k]*WIDTH +: WIDTH]    = y_lane[k];
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            lane_a_q    <= '0;
            lane_b_q    <= '0;
            map_q       <= '0;
            used_q      <= '0;
            alumode_q   <= ALU_AND;
            opmode_q    <= OPM_AND;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            if (go) begin
                for (int k = 0; k < 3; k++) begin
                    lane_a_q[k] <= lused_d[k] ? req_a_i[lmap_d[k]*WIDTH +: WIDTH] : '0;
                    lane_b_q[k] <= lused_d[k] ? req_b_i[lmap_d[k]*WIDTH +: WIDTH] : '0;
                end
                map_q  <= lmap_d;
                used_q <= lused_d;
                case (lop)
                    2'b01:   begin alumode_q <= ALU_AND; opmode_q <= OPM_OR;  end
                    2'b10:   begin alumode_q <= ALU_XOR; opmode_q <= OPM_AND; end
                    default: begin alumode_q <= ALU_AND; opmode_q <= OPM_AND; end
                endcase
                rr_q  <= leader + 2'd1;
                cnt_q <= 2'(LAT);
            end else if (state_q == EXEC && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign req_ready_o   = (state_q == IDLE && !reset_i) ? member : 4'b0000;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_y_o       = rsp_y_q;
    assign dsp_a0_o      = lane_a_q[0];
    assign dsp_a1_o      = lane_a_q[1];
    assign dsp_a2_o      = lane_a_q[2];
    assign dsp_b0_o      = lane_b_q[0];
    assign dsp_b1_o      = lane_b_q[1];
    assign dsp_b2_o      = lane_b_q[2];
    assign dsp_alumode_o = alumode_q;
    assign dsp_opmode_o  = opmode_q;
    assign busy_o        = (state_q == EXEC);

endmodule

// File: tb/tb_dsp_simd_logic_sched.sv
// Randomized and directed bench for dsp_simd_logic_sched with a behavioural DSP and scheduler model.
module tb_dsp_simd_logic_sched;
    localparam int W   = 12;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    rv, rdy, rsv, rsr;
    logic [7:0]    op;
    logic [4*W-1:0] a, b, y;
    logic [W-1:0]  da0, da1, da2, db0, db1, db2, dy0, dy1, dy2;
    logic [3:0]    alu;
    logic [8:0]    opm;
    logic          busy;

    dsp_simd_logic_sched #(.WIDTH(W), .LAT(LAT)) dut (
        .clock_i(clk), .reset_i(rst),
        .req_valid_i(rv), .req_ready_o(rdy), .req_op_i(op), .req_a_i(a), .req_b_i(b),
        .rsp_valid_o(rsv), .rsp_ready_i(rsr), .rsp_y_o(y),
        .dsp_a0_o(da0), .dsp_a1_o(da1), .dsp_a2_o(da2),
        .dsp_b0_o(db0), .dsp_b1_o(db1), .dsp_b2_o(db2),
        .dsp_alumode_o(alu), .dsp_opmode_o(opm),
        .dsp_y0_i(dy0), .dsp_y1_i(dy1), .dsp_y2_i(dy2),
        .busy_o(busy)
    );

    // External DSP: decodes ALUMODE/OPMODE into a lane logic op, LAT register stages.
    function automatic logic [W-1:0] dsp_f(logic [W-1:0] x, logic [W-1:0] z, logic [3:0] am, logic [8:0] om);
        if (am == 4'b1100 && om == 9'b000110011) return x & z;
        if (am == 4'b1100 && om == 9'b000111011) return x | z;
        if (am == 4'b0100 && om == 9'b000110011) return x ^ z;
        return ~(x & z);
    endfunction

    logic [3*W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {dsp_f(da2, db2, alu, opm), dsp_f(da1, db1, alu, opm), dsp_f(da0, db0, alu, opm)};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {dy2, dy1, dy0} = pipe[LAT-1];

    int n_chk = 0, n_fail = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            m_rr, m_exec, m_lop;
    bit [3:0]      m_rv;
    logic [W-1:0]  m_ry [4];
    int            m_bq[$];
    logic [W-1:0]  m_bres[$];
    logic [3:0]    m_alu;
    logic [8:0]    m_opm;
    logic [W-1:0]  m_la [3], m_lb [3];
    int            m_mem[$];

    task automatic m_reset();
        m_rr = 0; m_rv = '0; m_exec = 0;
        for (int i = 0; i < 4; i++) m_ry[i] = '0;
        for (int k = 0; k < 3; k++) begin m_la[k] = '0; m_lb[k] = '0; end
        m_bq.delete(); m_bres.delete();
        m_alu = 4'b1100; m_opm = 9'b000110011;
    endtask

    function automatic int nop(int i);
        logic [7:0] o = op;
        int r = int'(o[2*i +: 2]);
        return (r == 3) ? 0 : r;
    endfunction

    task automatic calc();
        m_mem.delete();
        if (m_exec != 0 || rst) return;
        for (int j = 0; j < 4; j++) begin
            int i = (m_rr + j) % 4;
            if (rv[i] && !m_rv[i]) begin
                if (m_mem.size() == 0) begin m_mem.push_back(i); m_lop = nop(i); end
                else if (nop(i) == m_lop && m_mem.size() < 3) m_mem.push_back(i);
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] er = '0;
        calc();
        foreach (m_mem[k]) er[m_mem[k]] = 1'b1;
        chk("req_ready", rdy, er);
        chk("busy", busy, m_exec != 0);
        chk("rsp_valid", rsv, m_rv);
        for (int i = 0; i < 4; i++) chk($sformatf("rsp_y%0d", i), y[i*W +: W], m_ry[i]);
        chk("alumode", alu, m_alu);
        chk("opmode", opm, m_opm);
        chk("lanes_a", {da2, da1, da0}, {m_la[2], m_la[1], m_la[0]});
        chk("lanes_b", {db2, db1, db0}, {m_lb[2], m_lb[1], m_lb[0]});
    endtask

    task automatic model_edge();
        if (rst) begin m_reset(); return; end
        m_rv &= ~rsr;
        if (m_exec > 0) begin
            m_exec--;
            if (m_exec == 0) begin
                foreach (m_bq[k]) begin m_rv[m_bq[k]] = 1'b1; m_ry[m_bq[k]] = m_bres[k]; end
                m_bq.delete(); m_bres.delete();
            end
        end else if (m_mem.size() > 0) begin
            m_bq = m_mem;
            for (int k = 0; k < 3; k++) begin m_la[k] = '0; m_lb[k] = '0; end
            foreach (m_mem[k]) begin
                logic [W-1:0] x = a[m_mem[k]*W +: W];
                logic [W-1:0] z = b[m_mem[k]*W +: W];
                m_la[k] = x; m_lb[k] = z;
                m_bres.push_back(m_lop == 1 ? (x | z) : m_lop == 2 ? (x ^ z) : (x & z));
            end
            m_alu  = (m_lop == 2) ? 4'b0100 : 4'b1100;
            m_opm  = (m_lop == 1) ? 9'b000111011 : 9'b000110011;
            m_rr   = (m_mem[0] + 1) % 4;
            m_exec = LAT + 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        rv = '0; rsr = 4'hF;
        repeat (LAT + 4) step();
        rsr = '0;
    endtask

    // Issue a lone request from requester 3 so the pointer lands on 0.
    task automatic set_rr0();
        rv = 4'b1000; op = '0;
        step();
        drain();
    endtask

    initial begin
        rst = 1'b1; rv = '0; rsr = '0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        rv = 4'hF;
        step();
        rst = 1'b0; rv = '0;

        // Single AND
        rv = 4'b0001; op = '0; a = 48'hF0F; b = 48'h0FF;
        step();
        rv = '0;
        repeat (3) step();
        chk("t1_y0", y[11:0], 12'h00F);
        drain();

        // Three-lane AND bundle
        set_rr0();
        rv = 4'b0111; op = '0; a = 48'hFFF_FFF_FFF_FFF; b = 48'h000_789_456_123;
        step();
        rv = '0;
        repeat (3) step();
        chk("t2_y", y[35:0], 36'h789_456_123);
        drain();

        // Mixed ops: {0,2} AND then {1} XOR
        set_rr0();
        rv = 4'b0111; op = 8'b00_00_10_00; a = 48'h000_FFF_AAA_FFF; b = 48'h000_00F_0F0_0F0;
        repeat (8) step();
        chk("t3_y1", y[23:12], 12'hA5A);
        drain();
        rv = 4'b0001; op = 8'b01; a = 48'hA00; b = 48'h00B;
        step();
        rv = '0;
        chk("t3_or_opm", opm, 9'b000111011);
        repeat (3) step();
        chk("t3_or_y0", y[11:0], 12'hA0B);
        drain();

        // Four AND requesters, three lanes
        set_rr0();
        rv = 4'hF; op = '0; a = 48'h123_456_789_ABC; b = 48'hFFF_0F0_F0F_FFF;
        repeat (8) step();
        drain();

        // Held response blocks re-request, others still served
        rv = 4'b0011; op = '0; a = 48'h0_0000_0055_033; b = 48'hFFF;
        repeat (8) step();
        rsr = 4'b0001;
        step();
        rsr = '0;
        repeat (4) step();
        drain();

        // Reset during EXEC discards the bundle
        rv = 4'b0001; op = '0; a = 48'h777; b = 48'hFFF;
        step();
        rv = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("t6_no_rsp", rsv, 4'b0000);
        rv = 4'b0100; op = 8'b10_0000; a = 48'h0F0_000_000; b = 48'h0FF_000_000;
        step();
        rv = '0;
        repeat (3) step();
        chk("t6_new_y2", y[35:24], 12'h00F);
        drain();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rv  = 4'($urandom);
            op  = 8'($urandom);
            a   = 48'({$urandom(), $urandom()});
            b   = 48'({$urandom(), $urandom()});
            rsr = 4'($urandom & $urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
